// File: rtl/memory_burst_pkg.sv
// Shared types and helpers for the burst memory: access-size encodings,
// FSM states and the beat-count decode.
package mem_pkg;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    typedef enum logic [1:0] {
        ACC_1  = SIZE_1,
        ACC_4  = SIZE_4,
        ACC_8  = SIZE_8,
        ACC_16 = SIZE_16
    } acc_size_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } st_t;

    function automatic logic [4:0] beats(input acc_size_t size);
        case (size)
            ACC_1:   return 5'd1;
            ACC_4:   return 5'd4;
            ACC_8:   return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/memory_burst_if.sv
// Request/response bundle between a bus master and the burst memory.
interface memory_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              enable;
    logic              read_write;
    logic [1:0]        access_size;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              err;

    modport master (
        output enable, read_write, access_size, address, data_in,
        input  busy, data_out, data_valid, err
    );

    modport slave (
        input  enable, read_write, access_size, address, data_in,
        output busy, data_out, data_valid, err
    );
endinterface

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM with registered read; contents are not reset.
module mem_sp_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1048576,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Read-first: a write beat returns the old word, which nobody consumes.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_burst.sv
// Word-organised memory with 1/4/8/16-beat bursts, base-relative byte
// addressing, range checking and a data_valid strobe.
module memory_burst
    import mem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1048576,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8002_0000
) (
    input logic           clk,
    input logic           reset,
    memory_burst_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * longint'(DEPTH_WORDS));

    st_t               state_q, state_d;
    logic              rw_q;
    logic              err_q;
    logic [3:0]        cnt_q;
    logic [3:0]        last_q;
    logic [AW-1:0]     ptr_q;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] hold_q;

    logic [ADDR_W-1:0] offset;
    logic              oor;
    logic [AW-1:0]     w0;
    logic              accept;
    logic              we_d;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_q;

    assign offset = bus.address - BASE_ADDR;
    assign oor    = (bus.address < BASE_ADDR) || ({1'b0, offset} >= LIMIT);
    assign w0     = offset[AW+1:2];
    assign accept = (state_q == ST_IDLE) && bus.enable;

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        valid_d  = 1'b0;
        ram_addr = w0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_BURST;
                    we_d    = !bus.read_write && !oor;
                    valid_d = bus.read_write;
                end
            end
            ST_BURST: begin
                ram_addr = ptr_q;
                if (cnt_q == last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    we_d    = !rw_q && !err_q;
                    valid_d = rw_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gates the write so nothing lands on the reset edge itself.
    mem_sp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we_d && !reset),
        .addr (ram_addr),
        .wdata(bus.data_in),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= 4'd0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (valid_q) hold_q <= bus.data_out;
            if (accept) begin
                rw_q   <= bus.read_write;
                err_q  <= oor;
                last_q <= 4'(beats(acc_size_t'(bus.access_size)) - 5'd1);
                cnt_q  <= 4'd0;
                ptr_q  <= w0 + AW'(1);
            end else if (state_q == ST_BURST) begin
                cnt_q <= (cnt_q == last_q) ? 4'd0 : cnt_q + 4'd1;
                ptr_q <= ptr_q + AW'(1);
            end
        end
    end

    assign bus.busy       = (state_q == ST_BURST);
    assign bus.err        = err_q && bus.busy;
    assign bus.data_valid = valid_q;
    assign bus.data_out   = valid_q ? (err_q ? '0 : ram_q) : hold_q;

endmodule

// File: tb/tb_memory_burst.sv
// Randomised bench for memory_burst against a word-array reference model.
module tb_memory_burst;

    localparam int          DW    = 32;
    localparam int          AWD   = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8002_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_burst_if #(.DATA_W(DW), .ADDR_W(AWD)) bus ();

    memory_burst #(
        .DATA_W     (DW),
        .ADDR_W     (AWD),
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wbuf  [16];
    logic [31:0] rbuf  [16];
    logic [31:0] last_read = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbeats(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (1 << (int'(size) + 1));
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
        return (a < BASE) || ((a - BASE) >= 32'(4 * DEPTH));
    endfunction

    task automatic xfer(input bit rw, input logic [1:0] size, input logic [31:0] addr, input bit noise);
        int          len;
        bit          oor;
        int          w0;
        logic [31:0] exp;
        len = nbeats(size);
        oor = out_of_range(addr);
        w0  = oor ? 0 : int'((addr - BASE) >> 2);
        @(negedge clk);
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        check("idle_before", 32'(bus.busy), 32'd0);
        bus.enable      = 1'b1;
        bus.read_write  = rw;
        bus.access_size = size;
        bus.address     = addr;
        bus.data_in     = wbuf[0];
        @(posedge clk);
        if (!rw && !oor) model[w0] = wbuf[0];
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            check("busy", 32'(bus.busy), 32'd1);
            check("err", 32'(bus.err), 32'(oor));
            check("valid", 32'(bus.data_valid), 32'(rw));
            if (rw) begin
                exp = oor ? 32'd0 : model[(w0 + k - 1) % DEPTH];
                check("rdata", bus.data_out, exp);
                rbuf[k-1] = bus.data_out;
                last_read = exp;
            end
            if (noise) begin
                bus.enable      = 1'($urandom);
                bus.read_write  = 1'($urandom);
                bus.access_size = 2'($urandom);
                bus.address     = BASE + 32'($urandom_range(0, 63));
            end else begin
                bus.enable = 1'b0;
            end
            if (!rw && k < len) begin
                bus.data_in = wbuf[k];
                if (!oor) model[(w0 + k) % DEPTH] = wbuf[k];
            end else if (rw) begin
                bus.data_in = $urandom;
            end
        end
        @(negedge clk);
        bus.enable = 1'b0;
        check("busy_end", 32'(bus.busy), 32'd0);
        check("valid_end", 32'(bus.data_valid), 32'd0);
        check("err_end", 32'(bus.err), 32'd0);
        check("hold", bus.data_out, last_read);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.read_write  = 1'b0;
        bus.access_size = 2'b00;
        bus.address     = 32'd0;
        bus.data_in     = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_dout", bus.data_out, 32'd0);
        reset = 1'b0;

        // Fill every word so the model is fully defined.
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        xfer(1'b0, 2'b11, BASE, 1'b0);

        wbuf[0] = 32'hDEAD_BEEF;
        xfer(1'b0, 2'b00, BASE, 1'b0);
        xfer(1'b1, 2'b00, BASE, 1'b0);
        check("single_rd", rbuf[0], 32'hDEAD_BEEF);

        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        xfer(1'b0, 2'b01, BASE + 32'h10, 1'b0);
        xfer(1'b1, 2'b01, BASE + 32'h10, 1'b0);
        check("b4_0", rbuf[0], 32'h11);
        check("b4_3", rbuf[3], 32'h44);

        for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
        xfer(1'b0, 2'b11, BASE + 32'h30, 1'b0);
        xfer(1'b1, 2'b11, BASE, 1'b0);
        check("wrap_w0", rbuf[0], 32'd4);
        check("wrap_w11", rbuf[11], 32'd15);

        xfer(1'b1, 2'b10, 32'h8001_FFFC, 1'b0);
        wbuf[0] = $urandom;
        xfer(1'b0, 2'b00, BASE + 32'(4 * DEPTH), 1'b0);
        xfer(1'b1, 2'b11, BASE, 1'b0);
        check("oor_w0", rbuf[0], 32'd4);

        xfer(1'b1, 2'b11, BASE + 32'h8, 1'b1);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else             a = BASE + 32'($urandom_range(0, 63));
            xfer(1'($urandom), 2'($urandom), a, 1'($urandom));
        end

        // Reset during beat 5 of an 8-beat write starting at word 4.
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        @(negedge clk);
        bus.enable      = 1'b1;
        bus.read_write  = 1'b0;
        bus.access_size = 2'b10;
        bus.address     = BASE + 32'h10;
        bus.data_in     = wbuf[0];
        @(posedge clk);
        model[4] = wbuf[0];
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.enable  = 1'b0;
            bus.data_in = wbuf[k];
            model[4 + k] = wbuf[k];
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        bus.data_in = wbuf[5];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_read = 32'd0;
        xfer(1'b1, 2'b11, BASE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_burst.md
Name: memory_burst

Overview:
- Parametrised, word-organised synchronous memory with single-word and burst transfers. Successor to the fixed 32-bit single-access memory.
- Serves as instruction/data memory for the MIPS pipeline and its loaders.
- Adds three things:
  - byte addressing relative to a base address, with range checking;
  - 4/8/16-beat bursts selected by access_size;
  - an explicit data_valid strobe alongside busy.

Parameters:
- DATA_W, 32: word width in bits.
- ADDR_W, 32: byte-address width.
- DEPTH_WORDS, 1048576: number of words; power of two, >=16.
- BASE_ADDR, 32'h8002_0000: byte address of word 0.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-high reset.
- enable  in  1: request strobe; sampled only when busy==0.
- read_write  in  1: 1 = read, 0 = write.
- access_size  in  2: 00 = 1 beat, 01 = 4 beats, 10 = 8 beats, 11 = 16 beats.
- address  in  ADDR_W: byte start address; bits [1:0] ignored.
- data_in  in  DATA_W: write data, one word per beat.
- busy  out  1: transfer in progress; new requests ignored.
- data_out  out  DATA_W: read data.
- data_valid  out  1: data_out holds a valid read beat this cycle.
- err  out  1: current transfer start address is out of range.

Behaviour:
- Reset (async, any time, including mid-burst):
  - busy=0, data_valid=0, err=0, data_out=0, state=IDLE, beat counter=0.
  - Array contents are not cleared; beats already written persist.
  - No write occurs on or after the reset edge until a new request.
- States: IDLE, BURST. Let L be the beat count (1/4/8/16), and N the edge at which enable==1 is sampled while IDLE.
- Accept at edge N:
  - latch read_write, L, and word index W0 = (address - BASE_ADDR) >> 2;
  - set state=BURST, busy=1, beat k=0.
- Addressing:
  - Beat k uses word index (W0 + k) mod DEPTH_WORDS, so a burst wraps from the last word to word 0.
- Out of range:
  - Out of range means address < BASE_ADDR or address - BASE_ADDR >= 4*DEPTH_WORDS.
  - err=1 for the whole transfer (same cycles as busy).
  - No array writes; read beats return 0 with data_valid still pulsed.
- Read:
  - Beat k is read at edge N+k and appears on data_out in cycle N+k+1, with data_valid=1.
  - data_valid is high for exactly L consecutive cycles (N+1..N+L).
  - data_out holds its last value after the burst; data_valid=0.
- Write:
  - data_in is sampled and written at edge N+k for k=0..L-1. Beat 0 is taken together with the request.
  - data_valid stays 0.
- busy timing (both modes):
  - busy is high in cycles N+1..N+L, then low; state returns to IDLE at edge N+L.
  - Earliest next accept is edge N+L+1.
- While busy:
  - enable, read_write, access_size and address are ignored; no queuing.
  - data_in is used only on write beat edges.
- Read-after-write: a read accepted after a write completes returns the new data. There are no same-cycle hazards because there is a single port.
- Counter: beat counter is 4 bits and terminates at L-1. access_size is decoded only at accept.

Decomposition:
- Package mem_pkg:
  - access_size enum (ACC_1, ACC_4, ACC_8, ACC_16);
  - state enum (ST_IDLE, ST_BURST);
  - function beats(access_size) returning 1/4/8/16;
  - constants for the access_size encodings.
- Sub-module mem_sp_ram:
  - single-port synchronous RAM (DATA_W x DEPTH_WORDS);
  - one write enable; registered read; no reset.
- memory_burst holds the FSM, the address and range logic, and the output registers.

Test Plan:
- Single write then read: write 0xDEADBEEF to 0x8002_0000 (size 00). Expect busy high 1 cycle, err=0. Then read the same address: data_out=0xDEADBEEF with data_valid high exactly 1 cycle, at cycle N+1.
- 4-beat burst: write 0x11,0x22,0x33,0x44 at 0x8002_0010 on consecutive edges, then read back with size 01. Expect data_valid high 4 consecutive cycles with values 0x11..0x44 in order, and busy high 4 cycles each time.
- Wrap-around: with DEPTH_WORDS=16, do a 16-beat write starting at word 12 (address 0x8002_0030) with data 0..15. Expect word 0 == 4 and word 11 == 15 on readback.
- Out of range: read 0x8001_FFFC with size 10. Expect err=1 and busy=1 for 8 cycles, data_valid pulsed 8 cycles with data 0, and no array change. A write to 0x8002_0000 + 4*DEPTH_WORDS leaves word 0 unchanged.
- Ignore while busy: toggle enable, address and read_write during a 16-beat read. Expect the sequence to be unaffected, no extra transfer, and the next accept only when busy==0.
- Reset mid-burst: assert reset at beat 5 of an 8-beat write. Expect busy, data_valid and err to fall asynchronously. Beats 0..4 are written and beats 5..7 keep their old contents.
